// File: rtl/hci_core_per_arbiter_if.sv
// HCI core bus bundle: request channel plus single-beat response channel.
// The initiator issues requests and consumes responses; the target does the opposite.
interface hci_core_intf #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32,
  parameter int unsigned UW = 1
) ();
  localparam int unsigned BW = DW / 8;

  logic          req;
  logic          gnt;
  logic [AW-1:0] add;
  logic          wen;
  logic [DW-1:0] data;
  logic [BW-1:0] be;
  logic          lrdy;
  logic [UW-1:0] user;
  logic          r_valid;
  logic [DW-1:0] r_data;
  logic          r_opc;
  logic [UW-1:0] r_user;

  modport initiator (
    output req, add, wen, data, be, lrdy, user,
    input  gnt, r_valid, r_data, r_opc, r_user
  );

  modport target (
    input  req, add, wen, data, be, lrdy, user,
    output gnt, r_valid, r_data, r_opc, r_user
  );
endinterface

// File: rtl/hci_core_per_arbiter.sv
// Round-robin arbiter sharing one single-outstanding HCI peripheral port among
// NB_REQ initiators. One transaction in flight; the response is routed back to
// the owner, and a timeout converts a missing response into an error response.
module hci_core_per_arbiter #(
  parameter int unsigned NB_REQ         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned DW             = 32,
  parameter int unsigned AW             = 32,
  parameter int unsigned UW             = 1,
  parameter int unsigned OW             = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  hci_core_intf.target    target [NB_REQ],
  hci_core_intf.initiator initiator,
  output logic            busy_o,
  output logic [OW-1:0]   owner_o,
  output logic            timeout_o
);

  localparam int unsigned   BW       = DW / 8;
  localparam int unsigned   CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [DW-1:0] ERR_DATA = DW'({((DW + 31) / 32){32'hbadacce5}});

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_ERROR
  } state_e;

  state_e        state_q, state_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [OW-1:0] owner_q, owner_d;
  logic          lock_q, lock_d;
  logic [OW-1:0] lock_idx_q, lock_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [OW-1:0] win;
  logic          found;
  logic          arb_en;

  // Flattened view of the requester ports so they can be indexed at run time.
  logic [NB_REQ-1:0] t_req, t_wen, t_lrdy, t_gnt, t_rvalid, t_ropc;
  logic [AW-1:0]     t_add   [NB_REQ];
  logic [DW-1:0]     t_data  [NB_REQ];
  logic [BW-1:0]     t_be    [NB_REQ];
  logic [UW-1:0]     t_user  [NB_REQ];
  logic [DW-1:0]     t_rdata [NB_REQ];
  logic [UW-1:0]     t_ruser [NB_REQ];

  logic          ini_req, ini_wen, ini_lrdy;
  logic [AW-1:0] ini_add;
  logic [DW-1:0] ini_data;
  logic [BW-1:0] ini_be;
  logic [UW-1:0] ini_user;

  for (genvar i = 0; i < NB_REQ; i++) begin : g_tgt
    assign t_req[i]          = target[i].req;
    assign t_wen[i]          = target[i].wen;
    assign t_lrdy[i]         = target[i].lrdy;
    assign t_add[i]          = target[i].add;
    assign t_data[i]         = target[i].data;
    assign t_be[i]           = target[i].be;
    assign t_user[i]         = target[i].user;
    assign target[i].gnt     = t_gnt[i];
    assign target[i].r_valid = t_rvalid[i];
    assign target[i].r_data  = t_rdata[i];
    assign target[i].r_opc   = t_ropc[i];
    assign target[i].r_user  = t_ruser[i];
  end

  assign initiator.req  = ini_req;
  assign initiator.add  = ini_add;
  assign initiator.wen  = ini_wen;
  assign initiator.data = ini_data;
  assign initiator.be   = ini_be;
  assign initiator.lrdy = ini_lrdy;
  assign initiator.user = ini_user;

  // Winner selection: first active request from the priority head, unless a
  // stalled request is locked in, which must stay presented until granted.
  always_comb begin
    logic [OW-1:0] idx;
    win   = ptr_q;
    found = 1'b0;
    for (int k = 0; k < NB_REQ; k++) begin
      idx = OW'((int'(ptr_q) + k) % int'(NB_REQ));
      if (!found && t_req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    if (lock_q) begin
      win = lock_idx_q;
    end
  end

  // Next-state, request forwarding and response routing.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    cnt_d      = cnt_q;
    arb_en     = 1'b0;
    t_gnt      = '0;
    t_rvalid   = '0;
    t_ropc     = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      t_rdata[i] = '0;
      t_ruser[i] = '0;
    end
    ini_req  = 1'b0;
    ini_add  = '0;
    ini_wen  = 1'b0;
    ini_data = '0;
    ini_be   = '0;
    ini_lrdy = 1'b0;
    ini_user = '0;

    unique case (state_q)
      ST_IDLE: begin
        arb_en = 1'b1;
      end
      ST_BUSY: begin
        if (initiator.r_valid) begin
          arb_en             = 1'b1;
          t_rvalid[owner_q]  = 1'b1;
          t_rdata[owner_q]   = initiator.r_data;
          t_ropc[owner_q]    = initiator.r_opc;
          t_ruser[owner_q]   = initiator.r_user;
          state_d            = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_ERROR: begin
        t_rvalid[owner_q] = 1'b1;
        t_rdata[owner_q]  = ERR_DATA;
        t_ropc[owner_q]   = 1'b1;
        state_d           = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A grant in the response cycle overrides the BUSY->IDLE decision above.
    if (arb_en) begin
      ini_req    = t_req[win];
      ini_add    = t_add[win];
      ini_wen    = t_wen[win];
      ini_data   = t_data[win];
      ini_be     = t_be[win];
      ini_lrdy   = t_lrdy[win];
      ini_user   = t_user[win];
      t_gnt[win] = initiator.gnt & t_req[win];
      if (t_req[win] && initiator.gnt) begin
        owner_d = win;
        ptr_d   = (win == OW'(NB_REQ - 1)) ? '0 : win + 1'b1;
        cnt_d   = '0;
        lock_d  = 1'b0;
        state_d = ST_BUSY;
      end else if (t_req[win]) begin
        lock_d     = 1'b1;
        lock_idx_d = win;
      end
    end
  end

  // State registers; soft clear has exactly the effect of reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge.
    if (rst_i || clear_i) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      cnt_q      <= cnt_d;
    end
  end

  assign busy_o    = (state_q == ST_BUSY);
  assign owner_o   = owner_q;
  assign timeout_o = (state_q == ST_ERROR);

endmodule

// File: tb/tb_hci_core_per_arbiter.sv
// Bench for hci_core_per_arbiter: a transaction-level model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_hci_core_per_arbiter;
  localparam int          NB       = 4;
  localparam int          TMO      = 8;
  localparam logic [31:0] ERR_WORD = 32'hbadacce5;

  logic clk = 1'b0;
  logic rst_i;
  logic clear_i;
  always #5 clk = ~clk;

  hci_core_intf tgt [NB] ();
  hci_core_intf ini ();

  logic       busy_o;
  logic [1:0] owner_o;
  logic       timeout_o;

  hci_core_per_arbiter #(
    .NB_REQ         (NB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .clear_i   (clear_i),
    .target    (tgt),
    .initiator (ini),
    .busy_o    (busy_o),
    .owner_o   (owner_o),
    .timeout_o (timeout_o)
  );

  // Requester-side stimulus and observation.
  logic          req   [NB];
  logic [31:0]   add   [NB];
  logic          wen   [NB];
  logic [31:0]   wdata [NB];
  logic [NB-1:0] o_gnt;
  logic [NB-1:0] o_rv;
  logic [NB-1:0] o_ropc;
  logic [31:0]   o_rd  [NB];

  for (genvar i = 0; i < NB; i++) begin : g_req
    assign tgt[i].req  = req[i];
    assign tgt[i].add  = add[i];
    assign tgt[i].wen  = wen[i];
    assign tgt[i].data = wdata[i];
    assign tgt[i].be   = 4'hf;
    assign tgt[i].lrdy = 1'b1;
    assign tgt[i].user = 1'b0;
    assign o_gnt[i]    = tgt[i].gnt;
    assign o_rv[i]     = tgt[i].r_valid;
    assign o_ropc[i]   = tgt[i].r_opc;
    assign o_rd[i]     = tgt[i].r_data;
  end

  int n_cmp  = 0;
  int n_fail = 0;
  bit mdl_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who is in flight, how long it has waited, who
  // holds priority, and whether a stalled request has been pinned.
  bit m_busy = 0, m_err = 0, m_lock = 0;
  int m_owner = 0, m_ptr = 0, m_lock_idx = 0, m_wait = 0;

  // Compare every cycle at the falling edge, then advance the model.
  always @(negedge clk) begin
    int          w;
    bit          arb, fwd, grant, e_rv;
    logic [31:0] e_rd;
    logic        e_opc;
    if (mdl_on) begin
      arb = (!m_busy && !m_err) || (m_busy && ini.r_valid);
      w = -1;
      if (m_lock) w = m_lock_idx;
      else
        for (int k = 0; k < NB; k++)
          if (w < 0 && req[(m_ptr + k) % NB]) w = (m_ptr + k) % NB;
      fwd   = arb && (w >= 0) && req[w];
      grant = fwd && ini.gnt;

      check("ini_req", ini.req, fwd);
      if (fwd) check("ini_add", ini.add, add[w]);
      check("busy_o", busy_o, m_busy);
      check("owner_o", owner_o, 64'(m_owner));
      check("timeout_o", timeout_o, m_err);
      for (int i = 0; i < NB; i++) begin
        e_rv  = (i == m_owner) && ((m_busy && ini.r_valid) || m_err);
        e_rd  = !e_rv ? 32'h0 : (m_err ? ERR_WORD : ini.r_data);
        e_opc = !e_rv ? 1'b0 : (m_err ? 1'b1 : ini.r_opc);
        check($sformatf("gnt%0d", i), o_gnt[i], grant && (w == i));
        check($sformatf("r_valid%0d", i), o_rv[i], e_rv);
        check($sformatf("r_data%0d", i), o_rd[i], e_rd);
        check($sformatf("r_opc%0d", i), o_ropc[i], e_opc);
      end

      if (rst_i || clear_i) begin
        m_busy = 0; m_err = 0; m_lock = 0;
        m_owner = 0; m_ptr = 0; m_lock_idx = 0; m_wait = 0;
      end else begin
        if (m_err) m_err = 0;
        else if (m_busy) begin
          if (ini.r_valid) m_busy = 0;
          else begin
            m_wait++;
            if (m_wait == TMO) begin
              m_busy = 0;
              m_err  = 1;
            end
          end
        end
        if (grant) begin
          m_busy  = 1;
          m_owner = w;
          m_ptr   = (w + 1) % NB;
          m_wait  = 0;
          m_lock  = 0;
        end else if (fwd) begin
          m_lock     = 1;
          m_lock_idx = w;
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int rr_exp[5] = '{0, 1, 2, 3, 0};
    int g;
    int tmo_cnt;

    rst_i = 1'b1;
    clear_i = 1'b0;
    for (int i = 0; i < NB; i++) begin
      req[i] = 1'b0; add[i] = '0; wen[i] = 1'b0; wdata[i] = '0;
    end
    ini.gnt = 1'b0; ini.r_valid = 1'b0; ini.r_data = '0; ini.r_opc = 1'b0; ini.r_user = '0;

    // Reset state
    nxt();
    mdl_on = 1'b1;
    nxt();
    smp();
    check("rst_busy", busy_o, 0);
    check("rst_owner", owner_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_ini_req", ini.req, 0);
    nxt();
    rst_i = 1'b0;
    nxt();

    // Single read from target 2, response three cycles after the grant
    req[2] = 1'b1; add[2] = 32'h1A100004; wen[2] = 1'b1; ini.gnt = 1'b1;
    smp();
    check("sr_gnt2", o_gnt[2], 1);
    check("sr_add", ini.add, 32'h1A100004);
    check("sr_busy_c0", busy_o, 0);
    nxt();
    req[2] = 1'b0; wen[2] = 1'b0; ini.gnt = 1'b0;
    smp();
    check("sr_busy_c1", busy_o, 1);
    check("sr_owner", owner_o, 2);
    nxt();
    smp();
    check("sr_busy_c2", busy_o, 1);
    nxt();
    ini.r_valid = 1'b1; ini.r_data = 32'hCAFEF00D;
    smp();
    check("sr_rv2", o_rv[2], 1);
    check("sr_rd2", o_rd[2], 32'hCAFEF00D);
    check("sr_rv_others", {o_rv[3], o_rv[1], o_rv[0]}, 0);
    check("sr_busy_c3", busy_o, 1);
    nxt();
    ini.r_valid = 1'b0; ini.r_data = '0;
    smp();
    check("sr_busy_c4", busy_o, 0);
    nxt();

    // Round robin with all requesters active and back-to-back responses
    clear_i = 1'b1;
    smp();
    nxt();
    clear_i = 1'b0;
    for (int i = 0; i < NB; i++) begin
      req[i] = 1'b1; add[i] = 32'h20000000 + 32'(i * 4);
    end
    ini.gnt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        ini.r_valid = 1'b1;
        ini.r_data  = 32'hA0000000 + 32'(k);
      end
      smp();
      g = -1;
      for (int i = 0; i < NB; i++) if (o_gnt[i]) g = i;
      check("rr_order", 64'(g), 64'(rr_exp[k]));
      if (k > 0) check("rr_resp_owner", o_rv[rr_exp[k-1]], 1);
      nxt();
    end
    for (int i = 0; i < NB; i++) req[i] = 1'b0;
    ini.r_data = 32'hA0000005;
    smp();
    check("rr_last_rv0", o_rv[0], 1);
    nxt();
    ini.r_valid = 1'b0; ini.gnt = 1'b0;
    smp();
    check("rr_idle", busy_o, 0);
    nxt();

    // Move the priority head to 3 by serving target 2
    req[2] = 1'b1; ini.gnt = 1'b1;
    smp();
    nxt();
    req[2] = 1'b0; ini.gnt = 1'b0; ini.r_valid = 1'b1;
    smp();
    nxt();
    ini.r_valid = 1'b0;

    // Lock: target 0 stalls five cycles; target 3 joins in cycle 2
    req[0] = 1'b1; add[0] = 32'h10000000;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        req[3] = 1'b1; add[3] = 32'h30000000;
      end
      smp();
      check("lk_add", ini.add, 32'h10000000);
      check("lk_no_gnt", o_gnt, 0);
      nxt();
    end
    ini.gnt = 1'b1;
    smp();
    check("lk_gnt0", o_gnt[0], 1);
    check("lk_gnt3", o_gnt[3], 0);
    nxt();
    req[0] = 1'b0;
    smp();
    nxt();
    ini.r_valid = 1'b1;
    smp();
    check("lk_next3", o_gnt[3], 1);
    check("lk_next_add", ini.add, 32'h30000000);
    nxt();
    req[3] = 1'b0;
    smp();
    check("lk_rv3", o_rv[3], 1);
    nxt();
    ini.r_valid = 1'b0; ini.gnt = 1'b0;

    // Timeout: target 1 granted, peripheral never answers
    req[1] = 1'b1; add[1] = 32'h1A100100; ini.gnt = 1'b1;
    smp();
    check("to_gnt1", o_gnt[1], 1);
    nxt();
    req[1] = 1'b0; ini.gnt = 1'b0;
    tmo_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      ini.r_valid = (c == 11);
      ini.r_data  = (c == 11) ? 32'h55555555 : 32'h0;
      smp();
      tmo_cnt += int'(timeout_o);
      if (c <= 8) check("to_busy", busy_o, 1);
      if (c == 9) begin
        check("to_rv1", o_rv[1], 1);
        check("to_rd1", o_rd[1], 32'hbadacce5);
        check("to_opc1", o_ropc[1], 1);
        check("to_pulse", timeout_o, 1);
      end
      if (c == 11) check("to_late_dropped", o_rv, 0);
      nxt();
    end
    ini.r_valid = 1'b0; ini.r_data = '0;
    check("to_pulse_count", 64'(tmo_cnt), 1);

    // Reset in the middle of a transaction owned by target 3
    req[3] = 1'b1; add[3] = 32'h30000040; ini.gnt = 1'b1;
    smp();
    check("rs_gnt3", o_gnt[3], 1);
    nxt();
    req[3] = 1'b0; ini.gnt = 1'b0;
    smp();
    check("rs_owner3", owner_o, 3);
    check("rs_busy", busy_o, 1);
    nxt();
    rst_i = 1'b1;
    smp();
    nxt();
    rst_i = 1'b0;
    smp();
    check("rs_idle", busy_o, 0);
    check("rs_owner0", owner_o, 0);
    check("rs_no_rv", o_rv, 0);
    nxt();

    // Clear in the same cycle as a response and a competing request
    req[1] = 1'b1; add[1] = 32'h1A100200; ini.gnt = 1'b1;
    smp();
    nxt();
    req[1] = 1'b0; ini.gnt = 1'b0;
    smp();
    nxt();
    ini.r_valid = 1'b1; ini.r_data = 32'h12345678; clear_i = 1'b1;
    req[2] = 1'b1; add[2] = 32'h1A100300; ini.gnt = 1'b1;
    smp();
    check("cl_rv1", o_rv[1], 1);
    check("cl_rd1", o_rd[1], 32'h12345678);
    check("cl_gnt2_comb", o_gnt[2], 1);
    nxt();
    clear_i = 1'b0; ini.r_valid = 1'b0; ini.r_data = '0; req[2] = 1'b0; ini.gnt = 1'b0;
    smp();
    check("cl_idle", busy_o, 0);
    check("cl_owner0", owner_o, 0);
    nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
